umult8: RTL and testbench



---
 rtl/wideword_pkg.sv | 13 +
 rtl/umult_lane.sv | 13 +
 rtl/umult8.sv | 65 ++++++
 tb/tb_umult8.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/wideword_pkg.sv
// Shared definitions for the WideWord 128-bit datapath: lane-width select codes and datapath width.
package wideword_pkg;

  localparam int unsigned DW = 128;

  typedef enum logic [1:0] {
    WW_RSVD = 2'b00,
    WW_8    = 2'b01,
    WW_16   = 2'b10,
    WW_32   = 2'b11
  } ww_e;

endpackage

// File: rtl/umult_lane.sv
// One unsigned lane multiplier: returns the low W bits of a*b (overflow discarded).
module umult_lane #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] p
);

  // Evaluating the product at W bits yields exactly the low half of the 2W-bit result.
  assign p = a * b;

endmodule

// File: rtl/umult8.sv
// Lane-wise unsigned multiplier for the 128-bit WideWord datapath; one-cycle registered result.
module umult8
  import wideword_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [0:DW-1] reg_A,
  input  logic [0:DW-1] reg_B,
  input  logic [0:1]    ctrl_ww,
  input  logic          in_valid,
  output logic [0:DW-1] result,
  output logic          out_valid
);

  logic [0:DW-1] prod8;
  logic [0:DW-1] prod16;
  logic [0:DW-1] prod32;
  logic [0:DW-1] lane_mux;

  // Lane k spans [k*W : k*W+W-1]; with ascending port ranges lane 0 lands on the MSB end.
  for (genvar k = 0; k < DW / 8; k++) begin : g_w8
    umult_lane #(.W(8)) u_lane (
      .a (reg_A[k*8 +: 8]),
      .b (reg_B[k*8 +: 8]),
      .p (prod8[k*8 +: 8])
    );
  end

  for (genvar k = 0; k < DW / 16; k++) begin : g_w16
    umult_lane #(.W(16)) u_lane (
      .a (reg_A[k*16 +: 16]),
      .b (reg_B[k*16 +: 16]),
      .p (prod16[k*16 +: 16])
    );
  end

  for (genvar k = 0; k < DW / 32; k++) begin : g_w32
    umult_lane #(.W(32)) u_lane (
      .a (reg_A[k*32 +: 32]),
      .b (reg_B[k*32 +: 32]),
      .p (prod32[k*32 +: 32])
    );
  end

  always_comb begin
    lane_mux = '0;
    unique case (ww_e'(ctrl_ww))
      WW_8:    lane_mux = prod8;
      WW_16:   lane_mux = prod16;
      WW_32:   lane_mux = prod32;
      WW_RSVD: lane_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) result <= lane_mux;
    end
  end

endmodule

// File: tb/tb_umult8.sv
// Self-checking bench for umult8: directed cases plus random traffic against an arithmetic lane model.
module tb_umult8;

  logic         clk;
  logic         rst_n;
  logic [127:0] reg_A;
  logic [127:0] reg_B;
  logic [1:0]   ctrl_ww;
  logic         in_valid;
  logic [127:0] result;
  logic         out_valid;

  int checks;
  int failures;
  logic [127:0] exp_r;
  logic         exp_v;

  umult8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .reg_A     (reg_A),
    .reg_B     (reg_B),
    .ctrl_ww   (ctrl_ww),
    .in_valid  (in_valid),
    .result    (result),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lane 0 is the most significant W bits of the 128-bit value.
  function automatic logic [127:0] model(input logic [127:0] a, input logic [127:0] b,
                                         input logic [1:0] ww);
    int unsigned w;
    logic [127:0] r;
    logic [127:0] mask;
    logic [63:0]  la, lb, pr;
    int unsigned sh;
    case (ww)
      2'b01:   w = 8;
      2'b10:   w = 16;
      2'b11:   w = 32;
      default: w = 0;
    endcase
    r = '0;
    if (w == 0) return r;
    mask = (128'd1 << w) - 128'd1;
    for (int k = 0; k < 128 / int'(w); k++) begin
      sh = 128 - (k + 1) * w;
      la = 64'((a >> sh) & mask);
      lb = 64'((b >> sh) & mask);
      pr = la * lb;
      r  = r | ((128'(pr) & mask) << sh);
    end
    return r;
  endfunction

  task automatic check(input string tag);
    checks++;
    assert (result === exp_r) else begin
      failures++;
      $error("FAIL %s result got=%h exp=%h", tag, result, exp_r);
    end
    checks++;
    assert (out_valid === exp_v) else begin
      failures++;
      $error("FAIL %s out_valid got=%b exp=%b", tag, out_valid, exp_v);
    end
  endtask

  task automatic step(input logic [127:0] a, input logic [127:0] b, input logic [1:0] ww,
                      input logic v, input string tag);
    @(negedge clk);
    reg_A    = a;
    reg_B    = b;
    ctrl_ww  = ww;
    in_valid = v;
    if (v) exp_r = model(a, b, ww);
    exp_v = v;
    @(posedge clk);
    #1;
    check(tag);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    reg_A    = '0;
    reg_B    = '0;
    ctrl_ww  = 2'b00;
    exp_r    = '0;
    exp_v    = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    step({4{32'h03000000}}, {4{32'h02000000}}, 2'b01, 1'b1, "w8_basic");
    assert (result === {4{32'h06000000}}) else begin
      failures++;
      $error("FAIL w8_const result got=%h exp=%h", result, {4{32'h06000000}});
    end
    checks++;
    step({4{32'h00030000}}, {4{32'h00020000}}, 2'b10, 1'b1, "w16_basic");
    step({128{1'b1}}, {128{1'b1}}, 2'b01, 1'b1, "w8_overflow");
    step({4{32'h0000FFFF}}, {4{32'h00000002}}, 2'b11, 1'b1, "w32_basic");
    step({4{32'h00010000}}, {4{32'h00010000}}, 2'b11, 1'b1, "w32_overflow");
    step({128{1'b1}}, {128{1'b1}}, 2'b10, 1'b1, "w16_allones");
    step({8{16'h1234}}, {8{16'h5678}}, 2'b00, 1'b1, "reserved");
    step({8{16'h1234}}, {8{16'h5678}}, 2'b11, 1'b1, "w32_pattern");
    step({128{1'b1}}, {128{1'b1}}, 2'b01, 1'b0, "idle_hold");
    step('0, '0, 2'b10, 1'b0, "idle_hold2");

    // Asynchronous reset in the middle of a cycle while result is nonzero.
    #2;
    rst_n = 1'b0;
    #1;
    exp_r = '0;
    exp_v = 1'b0;
    check("async_reset");
    @(negedge clk);
    reg_A    = {4{32'h11223344}};
    reg_B    = {4{32'h55667788}};
    ctrl_ww  = 2'b01;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("reset_held");
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("post_release");
    step({4{32'h11223344}}, {4{32'h55667788}}, 2'b01, 1'b1, "recover");

    for (int i = 0; i < 80; i++) begin
      step({$urandom, $urandom, $urandom, $urandom},
           {$urandom, $urandom, $urandom, $urandom},
           2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
